// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag controller for the async FIFO: binary address, Gray pointer,
// rptr synchronizer, registered full/almost-full/level. Optional macro: FIFO_OVERFLOW_DET_EN.
module fifo_wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_MARGIN = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_LEVEL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q;
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] level_next;
    logic              wwr;

    // rptr crosses from rclk here; only Gray code enters the flops.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
        end
    end

    assign wq_rptr    = sync_q[SYNC_STAGES-1];
    assign rbin_s     = gray2bin(wq_rptr);
    assign wwr        = winc & ~wfull;
    assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wwr};
    assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
    assign level_next = wbinnext - rbin_s;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            // Full when write pointer is one lap ahead: top two Gray bits inverted.
            wfull        <= (wgraynext == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]});
            walmost_full <= (level_next >= AFULL_LEVEL);
            wlevel       <= level_next;
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];

`ifdef FIFO_OVERFLOW_DET_EN
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            woverflow <= 1'b0;
        end else begin
            woverflow <= woverflow | (winc & wfull);
        end
    end
`else
    assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDRSIZE=4, AFULL_MARGIN=2, SYNC_STAGES=2).
module tb_fifo_wptr_full;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       wafull;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    // Reference state: write count, rptr sync pipe, registered flags
    int   m_wcnt;
    logic [4:0] m_s0, m_s1;
    logic m_full;
    logic m_ovf;

    fifo_wptr_full #(.ADDRSIZE(4), .AFULL_MARGIN(2), .SYNC_STAGES(2)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] bin2gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int gray2int(input logic [4:0] g);
        logic [4:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return int'(b);
    endfunction

    task automatic model_reset();
        m_wcnt = 0; m_s0 = '0; m_s1 = '0; m_full = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic step(input logic inc, input logic [4:0] rp);
        exp_t e, got;
        int   nb, lvl;
        winc = inc;
        rptr = rp;
        nb  = (m_wcnt + ((inc && !m_full) ? 1 : 0)) % 32;
        lvl = (nb - gray2int(m_s1) + 32) % 32;
`ifdef FIFO_OVERFLOW_DET_EN
        m_ovf = m_ovf | (inc & m_full);
`endif
        m_full = (lvl == 16);
        m_s1 = m_s0;
        m_s0 = rp;
        m_wcnt = nb;
        e.waddr = 4'(nb % 16);
        e.wptr = bin2gray(nb);
        e.wfull = m_full;
        e.wafull = (lvl >= 14);
        e.wlevel = 5'(lvl);
        e.wovf = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("waddr", 32'(waddr), 32'(got.waddr));
            chk("wptr", 32'(wptr), 32'(got.wptr));
            chk("wfull", 32'(wfull), 32'(got.wfull));
            chk("walmost_full", 32'(walmost_full), 32'(got.wafull));
            chk("wlevel", 32'(wlevel), 32'(got.wlevel));
            chk("woverflow", 32'(woverflow), 32'(got.wovf));
        end
    endtask

    task automatic do_reset_mid();
        #3;
        wrst = 1'b1;
        winc = 1'b1;
        #1;
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wptr", 32'(wptr), 0);
        chk("rst_wfull", 32'(wfull), 0);
        chk("rst_wafull", 32'(walmost_full), 0);
        chk("rst_wlevel", 32'(wlevel), 0);
        chk("rst_wovf", 32'(woverflow), 0);
        model_reset();
        @(posedge wclk);
        #1;
        chk("rst_hold_waddr", 32'(waddr), 0);
        wrst = 1'b0;
        winc = 1'b0;
    endtask

    initial begin
        logic [4:0] prev_wptr;
        logic [3:0] hold_addr;
        int rd;
        wrst = 1'b1;
        winc = 1'b1;
        rptr = '0;
        model_reset();
        #2;
        chk("por_wptr", 32'(wptr), 0);
        chk("por_wfull", 32'(wfull), 0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        winc = 1'b0;

        // 1: a few writes, then asynchronous reset mid-cycle with winc high
        for (int i = 0; i < 5; i++) step(1'b1, 5'd0);
        do_reset_mid();
        step(1'b0, 5'd0);
        chk("post_rst_waddr", 32'(waddr), 0);

        // 2: fill
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 5'd0);
            if (i == 13) chk("afull_w13", 32'(walmost_full), 0);
            if (i == 14) chk("afull_w14", 32'(walmost_full), 1);
            if (i == 15) chk("full_w15", 32'(wfull), 0);
        end
        chk("fill_wfull", 32'(wfull), 1);
        chk("fill_wlevel", 32'(wlevel), 16);
        chk("fill_wptr", 32'(wptr), 32'h18);

        // 3: writes while full are dropped
        hold_addr = waddr;
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0);
        chk("ovf_waddr", 32'(waddr), 32'(hold_addr));
        chk("ovf_wptr", 32'(wptr), 32'h18);
        chk("ovf_wlevel", 32'(wlevel), 16);
`ifdef FIFO_OVERFLOW_DET_EN
        chk("ovf_flag", 32'(woverflow), 1);
`else
        chk("ovf_flag", 32'(woverflow), 0);
`endif

        // 4: drain four entries; visible exactly three edges later
        step(1'b0, 5'b00110);
        step(1'b0, 5'b00110);
        chk("drain_e2_wfull", 32'(wfull), 1);
        step(1'b0, 5'b00110);
        chk("drain_e3_wfull", 32'(wfull), 0);
        chk("drain_e3_wlevel", 32'(wlevel), 12);
        chk("drain_e3_wafull", 32'(walmost_full), 0);

        // 5: wrap with rptr trailing by three entries
        do_reset_mid();
        prev_wptr = wptr;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i >= 3) ? bin2gray(i - 3) : 5'd0);
            chk("wrap_nofull", 32'(wfull), 0);
            chk("wrap_1bit", $countones(wptr ^ prev_wptr), 1);
            prev_wptr = wptr;
        end

        // 6: random writes and legal reads
        do_reset_mid();
        rd = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && ((m_wcnt - rd + 32) % 32) > 0)
                rd = (rd + 1) % 32;
            step(1'($urandom_range(0, 1) | (i < 60 ? 1 : 0)), bin2gray(rd));
            chk("rnd_lvl_bound", 32'(wlevel <= 5'd16), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
